cpu_input_port: RTL and testbench

- Input-side counterpart of the CPU output port. It takes FPGA switch and button inputs and presents them to CPU reads.
- Bits [7:0] of fpga_in are data switches. Bit 8 is an "enter" button.
- Each debounced press of enter captures the switch byte into a small FIFO.
- The CPU reads FIFO data, status, or live switch values over an addressed, registered read interface.

---
 rtl/cpu_input_port_if.sv | 21 ++
 rtl/cpu_input_port.sv | 179 +++++++++++++++++
 tb/tb_cpu_input_port.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_input_port_if.sv
// CPU read bus for the input port: strobe/address from the CPU, data/ready back.
interface cpu_input_port_if;
    logic       input_read_enable;
    logic [7:0] input_data_address;
    logic [7:0] input_data_out;
    logic       input_data_ready;

    modport master (
        output input_read_enable,
        output input_data_address,
        input  input_data_out,
        input  input_data_ready
    );

    modport slave (
        input  input_read_enable,
        input  input_data_address,
        output input_data_out,
        output input_data_ready
    );
endinterface

// File: rtl/cpu_input_port.sv
// Debounced switch/button input port: enter presses capture the switch byte into
// a FIFO that the CPU drains, along with status and live switch reads.
module cpu_input_port #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       fpga_in,
    cpu_input_port_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_e;

    logic [8:0]    sync1_q, sync2_q;
    logic [7:0]    sw_sync;
    logic          btn_sync;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          capture;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          ready_q, ready_d;
    logic          empty, full, pop, push, status_rd;

    assign sw_sync  = sync2_q[7:0];
    assign btn_sync = sync2_q[8];

    // Two-flop synchronizer for the asynchronous switch and button inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 9'h000;
            sync2_q <= 9'h000;
        end else begin
            sync1_q <= fpga_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM: a full stable window is needed to enter or leave PRESSED
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_sync) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = S_PRESSED;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PRESSED: begin
                if (!btn_sync) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_PRESSED;
                end
            end
            S_RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = S_PRESSED;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // FIFO bookkeeping and the registered CPU read mux; reads see pre-edge state
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == (AW+1)'(FIFO_DEPTH));
        pop       = bus.input_read_enable && (bus.input_data_address == 8'h00) && !empty;
        status_rd = bus.input_read_enable && (bus.input_data_address == 8'h01);
        push      = capture && (!full || pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = sw_sync;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end else begin
            count_d = count_q;
        end

        // A dropped capture sets the flag even when a status read clears it
        if (capture && full && !pop) begin
            ovf_d = 1'b1;
        end else if (status_rd) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        data_out_d = data_out_q;
        if (bus.input_read_enable) begin
            case (bus.input_data_address)
                8'h00:   data_out_d = empty ? 8'h00 : mem_q[rd_ptr_q];
                8'h01:   data_out_d = {4'(count_q), 1'b0, ovf_q, full, empty};
                8'h02:   data_out_d = sw_sync;
                default: data_out_d = 8'h00;
            endcase
        end else begin
            data_out_d = data_out_q;
        end

        ready_d = (count_d != '0);
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= '0;
            ovf_q      <= 1'b0;
            data_out_q <= 8'h00;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
        end
    end

    // FIFO storage; contents are meaningless until written so it has no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.input_data_out   = data_out_q;
    assign bus.input_data_ready = ready_q;
endmodule

// File: tb/tb_cpu_input_port.sv
// Scoreboard bench for cpu_input_port: reads queue expected bytes, a monitor checks them.
module tb_cpu_input_port;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] fpga_in = 9'h1FF;
    int         total = 0;
    int         bad = 0;

    typedef struct { logic [7:0] addr; logic [7:0] data; } exp_t;
    exp_t exp_q[$];

    cpu_input_port_if bus();

    cpu_input_port #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .fpga_in(fpga_in), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] expv);
        exp_t e;
        @(negedge clk);
        bus.input_read_enable  = 1'b1;
        bus.input_data_address = addr;
        e.addr = addr;
        e.data = expv;
        exp_q.push_back(e);
        @(negedge clk);
        bus.input_read_enable  = 1'b0;
    endtask

    task automatic press(input logic [7:0] sw);
        @(negedge clk);
        fpga_in = {1'b1, sw};
        repeat (12) @(negedge clk);
        fpga_in = {1'b0, sw};
        repeat (12) @(negedge clk);
    endtask

    // Monitor: every read strobe seen at an edge yields data 1 ns later
    always @(posedge clk) begin
        logic       pend;
        logic [7:0] a;
        exp_t       e;
        pend = bus.input_read_enable;
        a    = bus.input_data_address;
        #1;
        if (pend) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: addr %0h got %0h expected none", a, bus.input_data_out);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("read_addr_%0h", e.addr), bus.input_data_out, e.data);
            end
        end
    end

    initial begin
        int n;
        bus.input_read_enable  = 1'b0;
        bus.input_data_address = 8'h00;

        // Reset with all inputs high
        repeat (5) @(negedge clk);
        check("reset_data_out", bus.input_data_out, 8'h00);
        check("reset_ready", {7'h00, bus.input_data_ready}, 8'h00);
        fpga_in = 9'h000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        do_read(8'h01, 8'h01);

        // Single clean press
        @(negedge clk);
        fpga_in = {1'b1, 8'hA5};
        for (n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (bus.input_data_ready) break;
        end
        check("press_latency_in_window", {7'h00, (n >= 5 && n <= 8)}, 8'h01);
        repeat (13) @(negedge clk);
        fpga_in = {1'b0, 8'hA5};
        repeat (10) @(negedge clk);
        do_read(8'h00, 8'hA5);
        check("ready_after_pop", {7'h00, bus.input_data_ready}, 8'h00);
        do_read(8'h01, 8'h01);

        // Bounce shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); fpga_in[8] = 1'b1;
            @(negedge clk);
            @(negedge clk); fpga_in[8] = 1'b0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("bounce_ready", {7'h00, bus.input_data_ready}, 8'h00);
        do_read(8'h01, 8'h01);

        // Overflow with five presses into a four-deep FIFO
        for (int i = 1; i <= 5; i++) press(8'(i));
        do_read(8'h01, 8'h46);
        do_read(8'h01, 8'h42);
        for (int i = 1; i <= 4; i++) do_read(8'h00, 8'(i));
        do_read(8'h00, 8'h00);

        // Live switches and an unmapped address
        @(negedge clk);
        fpga_in = {1'b0, 8'h3C};
        repeat (3) @(negedge clk);
        do_read(8'h02, 8'h3C);
        do_read(8'h7F, 8'h00);
        do_read(8'h01, 8'h01);

        // Pop in the same cycle as a capture into a full FIFO
        press(8'h11); press(8'h22); press(8'h33); press(8'h44);
        @(negedge clk);
        fpga_in = {1'b1, 8'h55};
        repeat (6) @(posedge clk);
        do_read(8'h00, 8'h11);
        check("ready_after_simul", {7'h00, bus.input_data_ready}, 8'h01);
        repeat (12) @(negedge clk);
        fpga_in = {1'b0, 8'h55};
        repeat (10) @(negedge clk);
        do_read(8'h01, 8'h42);
        do_read(8'h00, 8'h22);
        do_read(8'h00, 8'h33);
        do_read(8'h00, 8'h44);
        do_read(8'h00, 8'h55);
        do_read(8'h01, 8'h01);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
